// File: rtl/somador_sequencial_if.sv
// Handshake and data bundle for somador_sequencial.
// The sub line exists only when SOMADOR_SUB_EN is defined.
interface somador_sequencial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SOMADOR_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
`ifdef SOMADOR_SUB_EN
        output sub,
`endif
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SOMADOR_SUB_EN
        input  sub,
`endif
        output busy, done, s, cout, ovf
    );
endinterface

// File: rtl/somador_sequencial.sv
// Multi-cycle adder: CHUNK bits per clock, carry rippled through a register.
// Define SOMADOR_SUB_EN to add the sub port (a - b - cin as a + ~b + ~cin).
module somador_sequencial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic              clk,
    input logic              rst,
    somador_sequencial_if.slave bus
);
    localparam int M  = WIDTH / CHUNK;
    localparam int JW = (M > 1) ? $clog2(M) : 1;

    generate
        if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad
            $error("somador_sequencial: invalid WIDTH/CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SOMA, FIM} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] b_eff;
    logic [JW-1:0]    j_q;
    logic [CHUNK:0]   part;
    logic             c_q;
    logic             cout_q;
    logic             ovf_q;
    logic             a_msb;
    logic             b_msb;
    logic             b_inv;
    logic             c_init;
    logic             last;

`ifdef SOMADOR_SUB_EN
    assign b_inv = bus.sub;
`else
    assign b_inv = 1'b0;
`endif

    // Subtraction folds into the adder: invert B and the carry-in.
    assign b_eff  = bus.b ^ {WIDTH{b_inv}};
    assign c_init = bus.cin ^ b_inv;

    // Operands are shifted down each cycle so the live chunk sits at bit 0;
    // the sum fills in from the top, landing in place after M shifts.
    assign part   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                  + (CHUNK+1)'(c_q);
    assign acc_nx = (acc_q >> CHUNK)
                  | (WIDTH'(part[CHUNK-1:0]) << (WIDTH - CHUNK));
    assign last   = (j_q == JW'(M - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = SOMA;
            SOMA:    if (last) state_nx = FIM;
            FIM:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, per-chunk add and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            s_q    <= '0;
            j_q    <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        b_q   <= b_eff;
                        c_q   <= c_init;
                        j_q   <= '0;
                        acc_q <= '0;
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= b_eff[WIDTH-1];
                    end
                end
                SOMA: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    c_q   <= part[CHUNK];
                    acc_q <= acc_nx;
                    j_q   <= j_q + JW'(1);
                    if (last) begin
                        s_q    <= acc_nx;
                        cout_q <= part[CHUNK];
                        ovf_q  <= (a_msb == b_msb) && (acc_nx[WIDTH-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == SOMA);
    assign bus.done = (state == FIM);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
